// File: rtl/iobus_port_ctrl.sv
// MCU I/O bus port block: output registers, input ports and a
// pixel-write window feeding a FIFO toward the display consumer.
module iobus_port_ctrl #(
  parameter int          N_OUT      = 4,
  parameter int          N_IN       = 4,
  parameter logic [31:0] OUT_BASE   = 32'h1100C000,
  parameter logic [31:0] IN_BASE    = 32'h11008000,
  parameter logic [31:0] GPU_BASE   = 32'h1100E000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          PX_ADDR_W  = 15,
  parameter int          PX_DATA_W  = 8
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic [31:0]           iobus_addr,
  input  logic [31:0]           iobus_out,
  input  logic                  iobus_wr,
  output logic [31:0]           iobus_in,
  input  logic [N_IN*32-1:0]    in_ports,
  output logic [N_OUT*32-1:0]   out_regs,
  output logic [N_OUT-1:0]      out_wr_stb,
  output logic                  px_valid,
  output logic [PX_ADDR_W-1:0]  px_addr,
  output logic [PX_DATA_W-1:0]  px_data,
  input  logic                  px_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [PX_ADDR_W-1:0] mem_a [FIFO_DEPTH];
  logic [PX_DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic [LW-1:0]        level;
  logic [PX_ADDR_W-1:0] pa;
  logic                 autoinc;
  logic                 ovf;
  logic [N_OUT-1:0]     out_hit;
  logic                 wr_pa;
  logic                 wr_px;
  logic                 wr_st;
  logic                 wr_ai;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push_acc;
  logic [31:0]          status;

  assign wr_pa = iobus_wr && (iobus_addr == GPU_BASE);
  assign wr_px = iobus_wr && (iobus_addr == GPU_BASE + 32'd4);
  assign wr_st = iobus_wr && (iobus_addr == GPU_BASE + 32'd8);
  assign wr_ai = iobus_wr && (iobus_addr == GPU_BASE + 32'd12);

  always_comb begin
    out_hit = '0;
    for (int k = 0; k < N_OUT; k++)
      out_hit[k] = iobus_wr &&
        (iobus_addr == OUT_BASE + 32'(4 * k));
  end

  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign pop      = px_valid && px_ready;
  // A full FIFO still accepts a push when a slot frees on the same edge
  assign push_acc = wr_px && (!full || pop);

  assign px_valid = !empty;
  assign px_addr  = mem_a[rp];
  assign px_data  = mem_d[rp];

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      out_regs   <= '0;
      out_wr_stb <= '0;
      pa         <= '0;
      autoinc    <= 1'b0;
      ovf        <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
    end else begin
      out_wr_stb <= out_hit;
      for (int k = 0; k < N_OUT; k++)
        if (out_hit[k])
          out_regs[32*k +: 32] <= iobus_out;
      if (wr_pa)
        pa <= iobus_out[PX_ADDR_W-1:0];
      else if (push_acc && autoinc)
        pa <= pa + PX_ADDR_W'(1);
      if (wr_ai)
        autoinc <= iobus_out[0];
      if (wr_px && full && !pop)
        ovf <= 1'b1;
      else if (wr_st && iobus_out[2])
        ovf <= 1'b0;
      if (push_acc)
        wp <= wp + AW'(1);
      if (pop)
        rp <= rp + AW'(1);
      case ({push_acc, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST_N && push_acc) begin
      mem_a[wp] <= pa;
      mem_d[wp] <= iobus_out[PX_DATA_W-1:0];
    end
  end

  always_comb begin
    status         = '0;
    status[0]      = full;
    status[1]      = empty;
    status[2]      = ovf;
    status[8 +: LW] = level;
  end

  always_comb begin
    iobus_in = '0;
    for (int k = 0; k < N_IN; k++)
      if (iobus_addr == IN_BASE + 32'(4 * k))
        iobus_in = in_ports[32*k +: 32];
    for (int k = 0; k < N_OUT; k++)
      if (iobus_addr == OUT_BASE + 32'(4 * k))
        iobus_in = out_regs[32*k +: 32];
    if (iobus_addr == GPU_BASE + 32'd8)
      iobus_in = status;
    if (iobus_addr == GPU_BASE + 32'd12)
      iobus_in = {31'b0, autoinc};
  end

endmodule

// File: tb/tb_iobus_port_ctrl.sv
// Directed bench for iobus_port_ctrl: register, port, pixel FIFO,
// overflow, full push/pop and reset scenarios.
module tb_iobus_port_ctrl;

  localparam logic [31:0] GPU = 32'h1100E000;

  logic         clk = 1'b0;
  logic         RST_N;
  logic [31:0]  iobus_addr;
  logic [31:0]  iobus_out;
  logic         iobus_wr;
  logic [31:0]  iobus_in;
  logic [127:0] in_ports;
  logic [127:0] out_regs;
  logic [3:0]   out_wr_stb;
  logic         px_valid;
  logic [14:0]  px_addr;
  logic [7:0]   px_data;
  logic         px_ready;

  int total = 0;
  int passed = 0;
  int failed = 0;

  iobus_port_ctrl dut (
    .clk        (clk),
    .RST_N      (RST_N),
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .iobus_in   (iobus_in),
    .in_ports   (in_ports),
    .out_regs   (out_regs),
    .out_wr_stb (out_wr_stb),
    .px_valid   (px_valid),
    .px_addr    (px_addr),
    .px_data    (px_data),
    .px_ready   (px_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    iobus_addr = a;
    #1;
    chk(tag, 128'(iobus_in), 128'(exp));
  endtask

  initial begin
    RST_N      = 1'b0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    in_ports   = '0;
    px_ready   = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;

    chk("rst_out_regs", out_regs, 128'd0);
    chk("rst_stb", 128'(out_wr_stb), 128'd0);
    chk("rst_px_valid", 128'(px_valid), 128'd0);
    rd("rst_status", GPU + 8, 32'h00000002);
    rd("rst_autoinc", GPU + 12, 32'h0);

    wr(32'h1100C004, 32'h0000ABCD);
    chk("out1_regs", out_regs, {32'h0, 32'h0, 32'h0000ABCD, 32'h0});
    chk("out1_stb", 128'(out_wr_stb), 128'h2);
    tick();
    chk("out1_stb_clr", 128'(out_wr_stb), 128'h0);
    rd("out1_read", 32'h1100C004, 32'h0000ABCD);

    wr(32'h1100C010, 32'hDEADBEEF);
    chk("bad_addr_regs", out_regs, {32'h0, 32'h0, 32'h0000ABCD, 32'h0});
    chk("bad_addr_stb", 128'(out_wr_stb), 128'h0);
    rd("bad_addr_read", 32'h1100C010, 32'h0);

    in_ports[95:64] = 32'h12345678;
    rd("in2_read", 32'h11008008, 32'h12345678);
    rd("in4_read", 32'h11008010, 32'h0);

    wr(GPU + 12, 32'h1);
    rd("autoinc_read", GPU + 12, 32'h1);
    wr(GPU, 32'h00007FFF);
    chk("pa_no_push", 128'(px_valid), 128'd0);
    wr(GPU + 4, 32'h11);
    chk("ai_v1", 128'(px_valid), 128'd1);
    chk("ai_h1", {px_addr, px_data}, {15'h7FFF, 8'h11});
    wr(GPU + 4, 32'h22);
    tick();
    chk("ai_hold", {px_addr, px_data}, {15'h7FFF, 8'h11});
    rd("ai_lvl2", GPU + 8, 32'h00000200);
    px_ready = 1'b1;
    tick();
    chk("ai_h2", {px_addr, px_data}, {15'h0000, 8'h22});
    tick();
    chk("ai_empty", 128'(px_valid), 128'd0);
    wr(GPU + 4, 32'h33);
    chk("ai_pa_next", {px_addr, px_data}, {15'h0001, 8'h33});
    tick();
    chk("ai_empty2", 128'(px_valid), 128'd0);

    px_ready = 1'b0;
    wr(GPU + 12, 32'h0);
    wr(GPU, 32'h100);
    for (int i = 0; i < 9; i++)
      wr(GPU + 4, 32'(i));
    rd("ovf_status", GPU + 8, 32'h00000805);
    chk("ovf_head", {px_addr, px_data}, {15'h100, 8'h00});
    wr(GPU + 8, 32'h4);
    rd("ovf_clear", GPU + 8, 32'h00000801);

    px_ready = 1'b1;
    wr(GPU + 4, 32'hAA);
    rd("fullpp_status", GPU + 8, 32'h00000801);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), 128'(px_data), 128'(i));
      tick();
    end
    chk("drain_last", 128'(px_data), 128'hAA);
    tick();
    chk("drain_empty", 128'(px_valid), 128'd0);

    px_ready = 1'b0;
    wr(32'h1100C000, 32'h5);
    wr(GPU + 4, 32'h1);
    wr(GPU + 4, 32'h2);
    wr(GPU + 4, 32'h3);
    rd("pre_rst_status", GPU + 8, 32'h00000300);
    wr(GPU + 12, 32'h1);
    RST_N      = 1'b0;
    px_ready   = 1'b1;
    iobus_addr = 32'h1100C000;
    iobus_out  = 32'h9;
    iobus_wr   = 1'b1;
    tick();
    RST_N    = 1'b1;
    iobus_wr = 1'b0;
    chk("mid_rst_valid", 128'(px_valid), 128'd0);
    chk("mid_rst_regs", out_regs, 128'd0);
    chk("mid_rst_stb", 128'(out_wr_stb), 128'd0);
    rd("mid_rst_status", GPU + 8, 32'h00000002);
    rd("mid_rst_ai", GPU + 12, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iobus_port_ctrl.md
IOBUS_PORT_CTRL -- requirements
Module: iobus_port_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- N_OUT, 4: number of 32-bit output registers.
- N_IN, 4: number of 32-bit input ports.
- OUT_BASE, 32'h1100C000: address of output register 0 (stride 4).
- IN_BASE, 32'h11008000: address of input port 0 (stride 4).
- GPU_BASE, 32'h1100E000: base address of the pixel-write window.
- FIFO_DEPTH, 8: pixel FIFO entries; power of 2, 2..256.
- PX_ADDR_W, 15: pixel address width.
- PX_DATA_W, 8: pixel data width.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state on its rising edge.
- RST_N, in, 1: synchronous, active-low reset.
- iobus_addr, in, 32: bus address.
- iobus_out, in, 32: write data from the MCU.
- iobus_wr, in, 1: write strobe, one cycle per store.
- iobus_in, out, 32: read data to the MCU.
- in_ports, in, N_IN*32: port k occupies bits [32k+31:32k].
- out_regs, out, N_OUT*32: output register contents, same packing.
- out_wr_stb, out, N_OUT: one-cycle pulse, registered with the write.
- px_valid, out, 1: FIFO head valid.
- px_addr, out, PX_ADDR_W: FIFO head pixel address.
- px_data, out, PX_DATA_W: FIFO head pixel data.
- px_ready, in, 1: the consumer takes the head when px_valid and px_ready are both high.

Function
REQ-003 Writes SHALL act only when iobus_wr=1 and iobus_addr exactly matches a decoded address. Every other address is ignored and causes no state change.
REQ-004 A write to OUT_BASE+4k (k<N_OUT) SHALL load out_regs[k] with all 32 bits of iobus_out on the next edge and pulse out_wr_stb[k] high for exactly that cycle.
REQ-005 iobus_in SHALL be combinational:
- IN_BASE+4k returns in_ports[k].
- OUT_BASE+4k returns out_regs[k].
- GPU_BASE+8 returns STATUS.
- GPU_BASE+12 returns {31'b0, autoinc}.
- Any other address returns 0.
REQ-006 GPU window, write side:
- GPU_BASE+0 loads the pixel address register PA from iobus_out[PX_ADDR_W-1:0].
- GPU_BASE+4 pushes {PA, iobus_out[PX_DATA_W-1:0]} into the FIFO.
- GPU_BASE+12 loads autoinc from iobus_out[0].
REQ-007 STATUS SHALL be laid out as follows:
- bit0: full.
- bit1: empty.
- bit2: overflow (sticky).
- bits[16:8]: level, 0..FIFO_DEPTH.
- all other bits: 0.
REQ-008 A write to GPU_BASE+8 with iobus_out[2]=1 SHALL clear overflow. All other bits of that write are ignored.
REQ-009 If the push is accepted and autoinc=1, PA SHALL increment by 1 on the same edge, wrapping from 2^PX_ADDR_W-1 to 0. If the push is dropped, PA is unchanged.
REQ-010 The FIFO SHALL be first-in first-out with level tracking. The head is presented on px_valid/px_addr/px_data, with px_valid = (level != 0).
REQ-011 A pushed entry SHALL first appear at the head on the cycle after the push edge. There is no same-cycle bypass.
REQ-012 A pop SHALL occur on an edge where px_valid=1 and px_ready=1. px_addr and px_data SHALL be held stable while px_valid=1 and px_ready=0.
REQ-013 Simultaneous push and pop SHALL leave the level unchanged. This holds when full too: the push is accepted because a slot frees on the same edge.
REQ-014 A push while full with no pop SHALL be dropped and set overflow=1. The FIFO contents and level are unchanged.
REQ-015 A pop when empty SHALL be impossible, because px_valid=0.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 A write to GPU_BASE+0 on the same edge as an auto-increment is not possible, since each cycle carries one address. PA SHALL follow whichever single write is present.

Reset
REQ-018 While RST_N=0 at a clock edge, the next state SHALL be:
- out_regs = 0 and out_wr_stb = 0.
- PA = 0 and autoinc = 0.
- FIFO empty (level 0) and overflow = 0.
- px_valid = 0.
REQ-019 Reset SHALL take priority over a simultaneous iobus_wr or pop. Entries in flight are discarded. px_addr and px_data are don't-care while px_valid=0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write 0x0000ABCD to 0x1100C004 -> out_regs[1]=0x0000ABCD and out_wr_stb=4'b0010 for one cycle; a read of 0x1100C004 returns 0x0000ABCD.
- With in_ports[2]=0x12345678, read 0x11008008 -> 0x12345678; read 0x11008010 -> 0.
- autoinc=1, PA=0x7FFF, two data writes 0x11 then 0x22, px_ready=1 -> pops (0x7FFF,0x11) then (0x0000,0x22); PA=0x0001 afterwards.
- px_ready=0, 9 data writes with depth 8 -> STATUS=0x00000805 (level 8, full, overflow); write 0x4 to GPU_BASE+8 -> STATUS=0x00000801.
- Full FIFO, px_ready=1, and a data write on the same cycle -> level stays 8, overflow stays 0, and the new entry is last out.
- RST_N=0 for one cycle mid-traffic with level 3 -> next cycle px_valid=0, STATUS=0x00000002, out_regs=0.
